// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Merges hazard-unit stalls, data-memory wait states and a fixed-latency
// MUL/DIV unit into per-stage enables and bubble/flush strobes.
// Optional feature macro: PERF_CNT_EN adds saturating per-source stall counters.
module pipeline_stall_ctrl #(
  parameter int unsigned MD_LATENCY = 8,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hz_stall,
  input  logic             hz_flush_IFID,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             md_start,
  output logic             en_PC,
  output logic             en_IFID,
  output logic             en_IDEX,
  output logic             en_EXMEM,
  output logic             en_MEMWB,
  output logic             flush_IFID,
  output logic             bubble_IDEX,
  output logic             bubble_EXMEM,
  output logic             bubble_MEMWB,
  output logic             md_done,
  output logic             busy
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_hz,
  output logic [CNT_W-1:0] perf_mem,
  output logic [CNT_W-1:0] perf_md
`endif
);

  localparam int unsigned CntBits = $clog2(MD_LATENCY);
  localparam logic [CntBits-1:0] CntLoad = CntBits'(MD_LATENCY - 2);

  typedef enum logic [0:0] {StRun, StMdBusy} state_e;

  state_e             r_state, w_state_d;
  logic [CntBits-1:0] r_cnt, w_cnt_d;
  logic               w_mem_stall;
  logic               w_md_freeze;
  logic               w_cnt_zero;

  assign w_mem_stall = dmem_req & ~dmem_ready;
  assign w_cnt_zero  = (r_cnt == '0);
  assign w_md_freeze = ((r_state == StRun) & md_start & ~w_mem_stall) |
                       ((r_state == StMdBusy) & ~w_cnt_zero);

  // State and latency counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StRun;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Next-state: the counter keeps running through memory waits, but release
  // at cnt==0 waits for MEM to be free so md_done is never lost under a stall.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StRun: begin
        if (md_start && !w_mem_stall) begin
          w_state_d = StMdBusy;
          w_cnt_d   = CntLoad;
        end
      end
      StMdBusy: begin
        if (!w_cnt_zero) begin
          w_cnt_d = r_cnt - CntBits'(1);
        end else if (!w_mem_stall) begin
          w_state_d = StRun;
        end
      end
      default: begin
        w_state_d = StRun;
        w_cnt_d   = '0;
      end
    endcase
  end

  // Output decode in priority order: reset, mem wait, MUL/DIV, hazard, run.
  always_comb begin
    en_PC        = 1'b1;
    en_IFID      = 1'b1;
    en_IDEX      = 1'b1;
    en_EXMEM     = 1'b1;
    en_MEMWB     = 1'b1;
    flush_IFID   = 1'b0;
    bubble_IDEX  = 1'b0;
    bubble_EXMEM = 1'b0;
    bubble_MEMWB = 1'b0;
    md_done      = 1'b0;
    busy         = 1'b0;
    if (!rst_n) begin
      en_PC        = 1'b0;
      en_IFID      = 1'b0;
      en_IDEX      = 1'b0;
      en_EXMEM     = 1'b0;
      en_MEMWB     = 1'b0;
      flush_IFID   = 1'b1;
      bubble_IDEX  = 1'b1;
      bubble_EXMEM = 1'b1;
      bubble_MEMWB = 1'b1;
    end else begin
      busy    = (r_state == StMdBusy);
      md_done = (r_state == StMdBusy) & w_cnt_zero & ~w_mem_stall;
      if (w_mem_stall) begin
        en_PC        = 1'b0;
        en_IFID      = 1'b0;
        en_IDEX      = 1'b0;
        en_EXMEM     = 1'b0;
        bubble_MEMWB = 1'b1;
      end else if (w_md_freeze) begin
        en_PC        = 1'b0;
        en_IFID      = 1'b0;
        en_IDEX      = 1'b0;
        bubble_EXMEM = 1'b1;
      end else if (hz_stall) begin
        en_PC       = 1'b0;
        en_IFID     = 1'b0;
        bubble_IDEX = 1'b1;
      end else begin
        // A branch held in ID re-raises the flush once it advances.
        flush_IFID = hz_flush_IFID;
      end
    end
  end

`ifdef PERF_CNT_EN
  logic w_win_mem;
  logic w_win_md;
  logic w_win_hz;

  assign w_win_mem = w_mem_stall;
  assign w_win_md  = ~w_mem_stall & w_md_freeze;
  assign w_win_hz  = ~w_mem_stall & ~w_md_freeze & hz_stall;

  // Saturating counters of cycles each stall source wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_hz  <= '0;
      perf_mem <= '0;
      perf_md  <= '0;
    end else begin
      if (w_win_hz && (perf_hz != '1)) perf_hz <= perf_hz + CNT_W'(1);
      if (w_win_mem && (perf_mem != '1)) perf_mem <= perf_mem + CNT_W'(1);
      if (w_win_md && (perf_md != '1)) perf_md <= perf_md + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl with MD_LATENCY=4.
// Each table row is one clock cycle: inputs applied after the falling edge,
// outputs compared before the next rising edge.
module tb_pipeline_stall_ctrl;

  localparam int unsigned MdLat = 4;
  localparam int unsigned CntW  = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic hz_stall, hz_flush_IFID, dmem_req, dmem_ready, md_start;
  logic en_PC, en_IFID, en_IDEX, en_EXMEM, en_MEMWB;
  logic flush_IFID, bubble_IDEX, bubble_EXMEM, bubble_MEMWB, md_done, busy;
`ifdef PERF_CNT_EN
  logic [CntW-1:0] perf_hz, perf_mem, perf_md;
`endif

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(
    .MD_LATENCY(MdLat),
    .CNT_W     (CntW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hz_stall     (hz_stall),
    .hz_flush_IFID(hz_flush_IFID),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .md_start     (md_start),
    .en_PC        (en_PC),
    .en_IFID      (en_IFID),
    .en_IDEX      (en_IDEX),
    .en_EXMEM     (en_EXMEM),
    .en_MEMWB     (en_MEMWB),
    .flush_IFID   (flush_IFID),
    .bubble_IDEX  (bubble_IDEX),
    .bubble_EXMEM (bubble_EXMEM),
    .bubble_MEMWB (bubble_MEMWB),
    .md_done      (md_done),
    .busy         (busy)
`ifdef PERF_CNT_EN
    ,
    .perf_hz      (perf_hz),
    .perf_mem     (perf_mem),
    .perf_md      (perf_md)
`endif
  );

  // Observed vector: {en_PC,en_IFID,en_IDEX,en_EXMEM,en_MEMWB,
  //                   flush_IFID,bubble_IDEX,bubble_EXMEM,bubble_MEMWB,md_done,busy}
  logic [10:0] obs;
  assign obs = {en_PC, en_IFID, en_IDEX, en_EXMEM, en_MEMWB,
                flush_IFID, bubble_IDEX, bubble_EXMEM, bubble_MEMWB, md_done, busy};

  // Expected patterns.
  localparam logic [10:0] ORst   = 11'b00000_1_111_0_0;
  localparam logic [10:0] ORun   = 11'b11111_0_000_0_0;
  localparam logic [10:0] ORunFl = 11'b11111_1_000_0_0;
  localparam logic [10:0] OHz    = 11'b00111_0_100_0_0;
  localparam logic [10:0] OMem   = 11'b00001_0_001_0_0;
  localparam logic [10:0] OMemB  = 11'b00001_0_001_0_1;
  localparam logic [10:0] OMd    = 11'b00011_0_010_0_0;
  localparam logic [10:0] OMdB   = 11'b00011_0_010_0_1;
  localparam logic [10:0] ODone  = 11'b11111_0_000_1_1;

  // Inputs: {hz_stall, hz_flush_IFID, dmem_req, dmem_ready, md_start}
  typedef struct {
    logic [4:0]  in;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[22];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] in);
    {hz_stall, hz_flush_IFID, dmem_req, dmem_ready, md_start} = in;
  endtask

  initial begin
    // Plain RUN-state cases.
    vecs[0]  = '{5'b00000, ORun};   // T1
    vecs[1]  = '{5'b10000, OHz};    // T2 stall cycle
    vecs[2]  = '{5'b01000, ORunFl}; // T5 flush alone
    vecs[3]  = '{5'b11000, OHz};    // T5 flush masked by stall
    vecs[4]  = '{5'b00110, ORun};   // access completes, no stall
    vecs[5]  = '{5'b00100, OMem};
    vecs[6]  = '{5'b11100, OMem};   // mem wait beats hazard
    vecs[7]  = '{5'b00101, OMem};   // md_start ignored under mem wait
    vecs[8]  = '{5'b00000, ORun};   // still RUN
    // T3: md_start with simultaneous hz_stall, MD_LATENCY=4.
    vecs[9]  = '{5'b10001, OMd};
    vecs[10] = '{5'b00000, OMdB};
    vecs[11] = '{5'b01001, OMdB};   // md_start ignored in MD_BUSY, flush masked
    vecs[12] = '{5'b00000, ODone};
    vecs[13] = '{5'b00000, ORun};
    // T4: memory wait over c1..c5 defers md_done to c6.
    vecs[14] = '{5'b00001, OMd};
    vecs[15] = '{5'b00100, OMemB};
    vecs[16] = '{5'b00100, OMemB};
    vecs[17] = '{5'b00100, OMemB};
    vecs[18] = '{5'b00100, OMemB};
    vecs[19] = '{5'b00100, OMemB};
    vecs[20] = '{5'b00000, ODone};
    vecs[21] = '{5'b00000, ORun};

    rst_n = 1'b0;
    drive(5'b10100);
    @(negedge clk);
    #1 check("reset_hold", 32'(obs), 32'(ORst));
`ifdef PERF_CNT_EN
    check("perf_hz_rst", perf_hz, 32'd0);
`endif
    rst_n = 1'b1;
    drive(5'b00000);

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(vecs[i].in);
      #1 check($sformatf("row%0d", i), 32'(obs), 32'(vecs[i].exp));
    end

    @(negedge clk);
    drive(5'b00000);
`ifdef PERF_CNT_EN
    #1;
    check("perf_hz", perf_hz, 32'd2);
    check("perf_mem", perf_mem, 32'd8);
    check("perf_md", perf_md, 32'd4);
`endif

    // T6: reset asserted at c2 of an MD op.
    @(negedge clk);
    drive(5'b00001);
    #1 check("t6_c0", 32'(obs), 32'(OMd));
    @(negedge clk);
    drive(5'b00000);
    #1 check("t6_c1", 32'(obs), 32'(OMdB));
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("t6_rst", 32'(obs), 32'(ORst));
`ifdef PERF_CNT_EN
    check("t6_perf_hz", perf_hz, 32'd0);
    check("t6_perf_mem", perf_mem, 32'd0);
    check("t6_perf_md", perf_md, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("t6_rel", 32'(obs), 32'(ORun));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 check($sformatf("t6_post%0d", i), 32'(obs), 32'(ORun));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
